fft16_output_reorder: RTL and testbench

Output reorder stage placed directly downstream of the radix-4 MDC 16-point FFT datapath. It accepts the serial complex output stream, which arrives in digit-reversed (base-4) order, one sample per cycle and with no stalls. It writes each sample into a ping-pong buffer at its natural frequency-bin address. Completed frames are then read out in natural bin order 0..15 through a valid/ready handshake.

---
 rtl/fft16_output_reorder.sv | 183 ++++++++++++++++++
 tb/tb_fft16_output_reorder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_output_reorder.sv
// Output reorder stage for the radix-4 MDC 16-point FFT.
// Digit-reversed input samples are written into a two-bank ping-pong buffer at their
// natural bin address; full banks are drained in bin order 0..15 over valid/ready.
module fft16_output_reorder #(
  parameter int unsigned WL = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WL-1:0] in_r,
  input  logic [WL-1:0] in_i,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic [WL-1:0] out_r,
  output logic [WL-1:0] out_i,
  output logic [3:0]    out_index,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eof,
  output logic          overflow
);

  typedef enum logic [1:0] {WrIdle, WrFill, WrDrop} wr_state_e;
  typedef enum logic [1:0] {BkEmpty, BkFull, BkDrain} bank_state_e;

  // Storage: address is {bank, bin}
  logic [WL-1:0] r_mem_r [32];
  logic [WL-1:0] r_mem_i [32];

  // Write side
  wr_state_e     r_wst;
  logic [3:0]    r_cnt;
  logic          r_wr_bank;
  logic          r_done;       // frame completed last edge; bank goes FULL this edge
  logic          r_done_bank;
  logic          r_overflow;

  // Read side
  bank_state_e   r_bank_st [2];
  logic          r_rd_bank;
  logic          r_out_valid;
  logic          r_out_sof;
  logic          r_out_eof;
  logic [3:0]    r_k;
  logic [WL-1:0] r_out_r;
  logic [WL-1:0] r_out_i;

  logic          w_bank_free;
  logic          w_we;
  logic [3:0]    w_wn;
  logic [4:0]    w_waddr;
  logic          w_hs;
  logic [3:0]    w_k_nxt;

  // Write-port decode: which sample (if any) is stored this cycle and where
  always_comb begin
    w_bank_free = (r_bank_st[r_wr_bank] == BkEmpty);
    w_we        = 1'b0;
    w_wn        = r_cnt;
    if (in_valid) begin
      if (in_sof) begin
        // A new frame always restarts at n=0, even when aborting a partial one
        w_we = w_bank_free;
        w_wn = 4'd0;
      end else if (r_wst == WrFill) begin
        w_we = 1'b1;
      end
    end
    // Swap the two base-4 digits of n to get the natural bin k
    w_waddr = {r_wr_bank, w_wn[1:0], w_wn[3:2]};
    w_hs    = r_out_valid && out_ready;
    w_k_nxt = r_k + 4'd1;
  end

  // Sample storage; contents are don't-care until a bank is marked FULL
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem_r[w_waddr] <= in_r;
      r_mem_i[w_waddr] <= in_i;
    end
  end

  // Write FSM: fill, drop or abort frames and track the sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wst       <= WrIdle;
      r_cnt       <= 4'd0;
      r_wr_bank   <= 1'b0;
      r_done      <= 1'b0;
      r_done_bank <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          // SOF mid-frame abandons the partial frame; its bank never left EMPTY
          if (r_wst != WrIdle) r_overflow <= 1'b1;
          r_cnt <= 4'd1;
          if (w_bank_free) begin
            r_wst <= WrFill;
          end else begin
            r_wst      <= WrDrop;
            r_overflow <= 1'b1;
          end
        end else begin
          unique case (r_wst)
            WrFill: begin
              if (r_cnt == 4'd15) begin
                r_wst       <= WrIdle;
                r_cnt       <= 4'd0;
                r_done      <= 1'b1;
                r_done_bank <= r_wr_bank;
                r_wr_bank   <= ~r_wr_bank;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
            WrDrop: begin
              if (r_cnt == 4'd15) begin
                r_wst <= WrIdle;
                r_cnt <= 4'd0;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Bank states and read FSM with a registered output word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_st[0] <= BkEmpty;
      r_bank_st[1] <= BkEmpty;
      r_rd_bank    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_k          <= 4'd0;
      r_out_r      <= '0;
      r_out_i      <= '0;
    end else begin
      // The completing bank was EMPTY, so it never collides with the read bank update
      if (r_done) r_bank_st[r_done_bank] <= BkFull;
      if (w_hs) begin
        if (r_k == 4'd15) begin
          r_bank_st[r_rd_bank] <= BkEmpty;
          r_rd_bank            <= ~r_rd_bank;
          r_out_valid          <= 1'b0;
          r_out_sof            <= 1'b0;
          r_out_eof            <= 1'b0;
          r_k                  <= 4'd0;
        end else begin
          r_k       <= w_k_nxt;
          r_out_r   <= r_mem_r[{r_rd_bank, w_k_nxt}];
          r_out_i   <= r_mem_i[{r_rd_bank, w_k_nxt}];
          r_out_sof <= 1'b0;
          r_out_eof <= (r_k == 4'd14);
        end
      end else if (!r_out_valid && r_bank_st[r_rd_bank] == BkFull) begin
        r_bank_st[r_rd_bank] <= BkDrain;
        r_out_valid          <= 1'b1;
        r_k                  <= 4'd0;
        r_out_r              <= r_mem_r[{r_rd_bank, 4'd0}];
        r_out_i              <= r_mem_i[{r_rd_bank, 4'd0}];
        r_out_sof            <= 1'b1;
        r_out_eof            <= 1'b0;
      end
    end
  end

  assign out_r     = r_out_r;
  assign out_i     = r_out_i;
  assign out_index = r_k;
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft16_output_reorder.sv
// Self-checking bench for fft16_output_reorder: table of digit-swapped bin order,
// plus directed sequences for latency, backpressure, overflow, abort and reset.
module tb_fft16_output_reorder;

  localparam int WL = 16;

  logic          clk;
  logic          rst;
  logic [WL-1:0] in_r;
  logic [WL-1:0] in_i;
  logic          in_valid;
  logic          in_sof;
  logic [WL-1:0] out_r;
  logic [WL-1:0] out_i;
  logic [3:0]    out_index;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eof;
  logic          overflow;

  fft16_output_reorder #(.WL(WL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_r      (in_r),
    .in_i      (in_i),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // One record per output position: bin k and the input sample n expected there
  typedef struct {
    int k;
    int exp_n;
  } vec_t;
  vec_t tbl [16];

  typedef struct packed {
    logic [WL-1:0] r;
    logic [WL-1:0] i;
    logic [3:0]    idx;
    logic          sof;
    logic          eof;
  } obs_t;

  obs_t obs_q [$];
  obs_t held;
  logic hold_pending;
  logic ovf_seen;
  logic bp_mode;
  int   cyc;
  int   nchk;
  int   nerr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bp_mode) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  // Capture every accepted word; a stalled word must not change until accepted
  always @(negedge clk) begin
    if (rst) begin
      hold_pending <= 1'b0;
    end else begin
      if (overflow) ovf_seen <= 1'b1;
      if (hold_pending) begin
        chk("hold_stable", {out_valid, out_r, out_i, out_index, out_sof, out_eof},
            {1'b1, held.r, held.i, held.idx, held.sof, held.eof});
      end
      if (out_valid && out_ready) begin
        obs_q.push_back('{r: out_r, i: out_i, idx: out_index, sof: out_sof, eof: out_eof});
        hold_pending <= 1'b0;
      end else if (out_valid) begin
        held         <= '{r: out_r, i: out_i, idx: out_index, sof: out_sof, eof: out_eof};
        hold_pending <= 1'b1;
      end else begin
        hold_pending <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    tick();
    tick();
    chk("reset_state", {out_valid, out_sof, out_eof, out_index, out_r, out_i, overflow}, '0);
    rst = 1'b0;
    obs_q.delete();
  endtask

  task automatic send_samples(input int base, input int first, input int last);
    for (int n = first; n <= last; n++) begin
      in_valid = 1'b1;
      in_sof   = (n == 0);
      in_r     = WL'(base + n);
      in_i     = WL'(-(base + n));
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int c;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("wait_obs_count", 64'(obs_q.size() >= n), 64'd1);
  endtask

  // Pop 16 words and compare them with the table-driven expected frame
  task automatic check_frame(input int base);
    obs_t got;
    obs_t exp;
    int   v;
    chk("frame_len", 64'(obs_q.size() >= 16), 64'd1);
    if (obs_q.size() >= 16) begin
      for (int j = 0; j < 16; j++) begin
        got = obs_q.pop_front();
        v   = base + tbl[j].exp_n;
        exp = '{r: WL'(v), i: WL'(-v), idx: 4'(tbl[j].k), sof: (j == 0), eof: (j == 15)};
        chk($sformatf("word_b%0d_k%0d", base, j), 64'(got), 64'(exp));
      end
    end
  endtask

  initial begin
    automatic int c;
    tbl[0]  = '{0, 0};  tbl[1]  = '{1, 4};  tbl[2]  = '{2, 8};  tbl[3]  = '{3, 12};
    tbl[4]  = '{4, 1};  tbl[5]  = '{5, 5};  tbl[6]  = '{6, 9};  tbl[7]  = '{7, 13};
    tbl[8]  = '{8, 2};  tbl[9]  = '{9, 6};  tbl[10] = '{10, 10}; tbl[11] = '{11, 14};
    tbl[12] = '{12, 3}; tbl[13] = '{13, 7}; tbl[14] = '{14, 11}; tbl[15] = '{15, 15};

    clk = 1'b0; rst = 1'b1; in_r = '0; in_i = '0; in_valid = 1'b0; in_sof = 1'b0;
    out_ready = 1'b1; bp_mode = 1'b0; cyc = 0; nchk = 0; nerr = 0;
    hold_pending = 1'b0; ovf_seen = 1'b0;

    // Single frame with first-word latency
    do_reset();
    send_samples(0, 0, 15);
    chk("lat_edge0_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_edge1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_edge2_word", {out_valid, out_index, out_sof, out_r}, {1'b1, 4'd0, 1'b1, 16'd0});
    wait_obs(16, 40);
    check_frame(0);

    // Back-to-back frames; one idle cycle between frames lets the drained bank free
    do_reset();
    ovf_seen = 1'b0;
    for (int f = 0; f < 4; f++) begin
      send_samples(16 * f, 0, 15);
      tick();
    end
    wait_obs(64, 120);
    chk("b2b_overflow", 64'(ovf_seen), 64'd0);
    for (int f = 0; f < 4; f++) check_frame(16 * f);

    // Backpressure with out_ready cycling 1,0,0,1
    do_reset();
    bp_mode = 1'b1;
    send_samples(0, 0, 15);
    wait_obs(16, 120);
    bp_mode   = 1'b0;
    out_ready = 1'b1;
    check_frame(0);
    chk("bp_no_extra", 64'(obs_q.size()), 64'd0);

    // Overflow: no bank free for the third frame
    do_reset();
    out_ready = 1'b0;
    send_samples(0, 0, 15);
    tick();
    send_samples(16, 0, 15);
    tick();
    chk("ovf_before_f2", 64'(overflow), 64'd0);
    send_samples(32, 0, 0);
    chk("ovf_at_f2_n0", 64'(overflow), 64'd1);
    send_samples(32, 1, 15);
    out_ready = 1'b1;
    wait_obs(32, 80);
    for (int i = 0; i < 40; i++) tick();
    chk("ovf_out_count", 64'(obs_q.size()), 64'd32);
    chk("ovf_valid_low", 64'(out_valid), 64'd0);
    check_frame(0);
    check_frame(16);

    // Frame abort: SOF at n=7 starts a fresh frame
    do_reset();
    send_samples(100, 0, 6);
    send_samples(200, 0, 15);
    chk("abort_overflow", 64'(overflow), 64'd1);
    wait_obs(16, 40);
    check_frame(200);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_extra", 64'(obs_q.size()), 64'd0);

    // Reset while k=5 is on the output (overflow is still set from the abort)
    send_samples(300, 0, 15);
    c = 0;
    while (!(out_valid && out_index == 4'd5) && c < 40) begin
      tick();
      c++;
    end
    chk("mid_drain_k5", {out_valid, out_index}, {1'b1, 4'd5});
    rst = 1'b1;
    tick();
    chk("mid_reset_valid", 64'(out_valid), 64'd0);
    chk("mid_reset_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    obs_q.delete();
    send_samples(400, 0, 15);
    wait_obs(16, 40);
    check_frame(400);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
